// File: rtl/axis_seq_checker.sv
// AXI-Stream sink: programmable backpressure, incrementing-sequence data check,
// frame/beat counting, frame-length and tuser checks with sticky error flags.
module axis_seq_checker #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned START_VALUE   = 1,
  parameter int unsigned MAX_FRAME_LEN = 16,
  parameter bit          HALT_ON_ERROR = 1'b0
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [7:0]            ready_pattern,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [15:0]           frame_count,
  output logic [31:0]           beat_count,
  output logic [15:0]           seq_err_count,
  output logic                  err_seq,
  output logic                  err_len,
  output logic                  err_user,
  output logic [DATA_WIDTH-1:0] first_data,
  output logic                  first_valid,
  output logic [1:0]            state
);

  localparam int unsigned BIF_W = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;
  localparam logic [BIF_W-1:0]      BIF_LAST  = BIF_W'(MAX_FRAME_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] EXP_RESET = DATA_WIDTH'(START_VALUE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [BIF_W-1:0]      bif_q, bif_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [15:0]           seq_err_cnt_q, seq_err_cnt_d;
  logic                  err_seq_q, err_seq_d;
  logic                  err_len_q, err_len_d;
  logic                  err_user_q, err_user_d;
  logic [DATA_WIDTH-1:0] first_data_q, first_data_d;
  logic                  first_valid_q, first_valid_d;

  logic xfer, seq_mis, len_err, user_err, any_err;

  // Next-state, counter and flag logic; clear overrides everything at the end.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    tready_d      = tready_q;
    expected_d    = expected_q;
    bif_d         = bif_q;
    frame_cnt_d   = frame_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    seq_err_cnt_d = seq_err_cnt_q;
    err_seq_d     = err_seq_q;
    err_len_d     = err_len_q;
    err_user_d    = err_user_q;
    first_data_d  = first_data_q;
    first_valid_d = first_valid_q;

    xfer     = input_axis_tvalid & tready_q;
    seq_mis  = xfer & (input_axis_tdata != expected_q);
    len_err  = xfer & ~input_axis_tlast & (bif_q == BIF_LAST);
    user_err = xfer & input_axis_tlast & input_axis_tuser;
    any_err  = seq_mis | len_err | user_err;

    if (xfer) begin
      expected_d = input_axis_tdata + DATA_WIDTH'(1);
      if (beat_cnt_q != 32'hFFFF_FFFF) beat_cnt_d = beat_cnt_q + 32'd1;
      if (seq_mis) begin
        err_seq_d = 1'b1;
        if (seq_err_cnt_q != 16'hFFFF) seq_err_cnt_d = seq_err_cnt_q + 16'd1;
      end
      if (!first_valid_q) begin
        first_data_d  = input_axis_tdata;
        first_valid_d = 1'b1;
      end
      if (input_axis_tlast) begin
        bif_d = '0;
        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        if (input_axis_tuser) err_user_d = 1'b1;
      end else if (len_err) begin
        bif_d     = '0;
        err_len_d = 1'b1;
      end else begin
        bif_d = bif_q + BIF_W'(1);
      end
    end

    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (HALT_ON_ERROR && any_err)    state_d = ST_HALT;
        else if (!enable && bif_d == '0) state_d = ST_IDLE;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    // Phase free-runs only while staying in ACTIVE, so each entry starts at phase 0.
    phase_d  = (state_q == ST_ACTIVE && state_d == ST_ACTIVE) ? phase_q + 3'd1 : 3'd0;
    tready_d = (state_d == ST_ACTIVE) & ready_pattern[phase_d];

    if (clear) begin
      state_d       = ST_IDLE;
      phase_d       = 3'd0;
      tready_d      = 1'b0;
      expected_d    = EXP_RESET;
      bif_d         = '0;
      frame_cnt_d   = 16'd0;
      beat_cnt_d    = 32'd0;
      seq_err_cnt_d = 16'd0;
      err_seq_d     = 1'b0;
      err_len_d     = 1'b0;
      err_user_d    = 1'b0;
      first_data_d  = '0;
      first_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= 3'd0;
      tready_q      <= 1'b0;
      expected_q    <= EXP_RESET;
      bif_q         <= '0;
      frame_cnt_q   <= 16'd0;
      beat_cnt_q    <= 32'd0;
      seq_err_cnt_q <= 16'd0;
      err_seq_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_user_q    <= 1'b0;
      first_data_q  <= '0;
      first_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      tready_q      <= tready_d;
      expected_q    <= expected_d;
      bif_q         <= bif_d;
      frame_cnt_q   <= frame_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      err_seq_q     <= err_seq_d;
      err_len_q     <= err_len_d;
      err_user_q    <= err_user_d;
      first_data_q  <= first_data_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign input_axis_tready = tready_q;
  assign frame_count       = frame_cnt_q;
  assign beat_count        = beat_cnt_q;
  assign seq_err_count     = seq_err_cnt_q;
  assign err_seq           = err_seq_q;
  assign err_len           = err_len_q;
  assign err_user          = err_user_q;
  assign first_data        = first_data_q;
  assign first_valid       = first_valid_q;
  assign state             = state_q;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: a non-halting and a halting instance
// share one source, both with a 4-beat frame limit.
module tb_axis_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pattern = 8'hFF;
  logic [7:0]  tdata = 8'd0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;

  logic        tready, h_tready;
  logic [15:0] frame_count, h_frame_count;
  logic [31:0] beat_count, h_beat_count;
  logic [15:0] seq_err_count, h_seq_err_count;
  logic        err_seq, err_len, err_user, h_err_seq, h_err_len, h_err_user;
  logic [7:0]  first_data, h_first_data;
  logic        first_valid, h_first_valid;
  logic [1:0]  state, h_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_seq_checker #(.DATA_WIDTH(8), .START_VALUE(1), .MAX_FRAME_LEN(4), .HALT_ON_ERROR(1'b0)) dut (
    .clk(clk), .async_rst_n(rst_n), .clear(clear), .enable(enable), .ready_pattern(pattern),
    .input_axis_tdata(tdata), .input_axis_tvalid(tvalid), .input_axis_tready(tready),
    .input_axis_tlast(tlast), .input_axis_tuser(tuser),
    .frame_count(frame_count), .beat_count(beat_count), .seq_err_count(seq_err_count),
    .err_seq(err_seq), .err_len(err_len), .err_user(err_user),
    .first_data(first_data), .first_valid(first_valid), .state(state));

  axis_seq_checker #(.DATA_WIDTH(8), .START_VALUE(1), .MAX_FRAME_LEN(4), .HALT_ON_ERROR(1'b1)) dut_h (
    .clk(clk), .async_rst_n(rst_n), .clear(clear), .enable(enable), .ready_pattern(pattern),
    .input_axis_tdata(tdata), .input_axis_tvalid(tvalid), .input_axis_tready(h_tready),
    .input_axis_tlast(tlast), .input_axis_tuser(tuser),
    .frame_count(h_frame_count), .beat_count(h_beat_count), .seq_err_count(h_seq_err_count),
    .err_seq(h_err_seq), .err_len(h_err_len), .err_user(h_err_user),
    .first_data(h_first_data), .first_valid(h_first_valid), .state(h_state));

  // Present one beat at a negedge and hold it until the main instance accepts it.
  task automatic send(input logic [7:0] d, input logic l, input logic u, output int waits);
    int n;
    n = 0;
    @(negedge clk);
    tdata = d; tlast = l; tuser = u; tvalid = 1'b1;
    while (tready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL send_timeout data=%0d tready=%b required 1", d, tready);
      tvalid = 1'b0;
    end else begin
      @(posedge clk);
    end
    waits = n;
  endtask

  task automatic go_idle();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    tvalid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL reset_tready got=%b exp=0", tready); end
    tests++; if (frame_count !== 16'd0 || beat_count !== 32'd0 || seq_err_count !== 16'd0) begin
      fails++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", frame_count, beat_count, seq_err_count); end
    tests++; if ({err_seq, err_len, err_user, first_valid} !== 4'b0000 || first_data !== 8'd0) begin
      fails++; $display("FAIL reset_flags got=%b fd=%0d exp=0000 fd=0", {err_seq, err_len, err_user, first_valid}, first_data); end
    tests++; if (h_state !== 2'd0) begin fails++; $display("FAIL reset_h_state got=%0d exp=0", h_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_incrementing();
    int w;
    pattern = 8'hFF;
    enable  = 1'b1;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, w);
    go_idle();
    tests++; if (first_data !== 8'd1 || first_valid !== 1'b1) begin
      fails++; $display("FAIL inc_first got=%0d/%b exp=1/1", first_data, first_valid); end
    tests++; if (frame_count !== 16'd5 || beat_count !== 32'd5) begin
      fails++; $display("FAIL inc_counts got=%0d/%0d exp=5/5", frame_count, beat_count); end
    tests++; if ({err_seq, err_len, err_user} !== 3'b000 || seq_err_count !== 16'd0) begin
      fails++; $display("FAIL inc_errors got=%b cnt=%0d exp=000 cnt=0", {err_seq, err_len, err_user}, seq_err_count); end
  endtask

  task automatic test_seq_error();
    int w;
    pulse_clear();
    send(8'd1, 1'b1, 1'b0, w);
    send(8'd2, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (err_seq !== 1'b0) begin fails++; $display("FAIL seq_before got=%b exp=0", err_seq); end
    send(8'd4, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (err_seq !== 1'b1 || seq_err_count !== 16'd1) begin
      fails++; $display("FAIL seq_bad_beat got=%b/%0d exp=1/1", err_seq, seq_err_count); end
    send(8'd5, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (seq_err_count !== 16'd1 || beat_count !== 32'd4) begin
      fails++; $display("FAIL seq_resync got=%0d/%0d exp=1/4", seq_err_count, beat_count); end
  endtask

  task automatic test_backpressure();
    int w;
    int wsum;
    pattern = 8'hAA;
    pulse_clear();
    repeat (2) @(negedge clk);
    wsum = 0;
    send(8'd1, 1'b1, 1'b0, w);
    for (int i = 2; i <= 8; i++) begin
      send(8'(i), 1'b1, 1'b0, w);
      wsum += w;
    end
    go_idle();
    tests++; if (wsum !== 7) begin fails++; $display("FAIL bp_alternate got=%0d exp=7", wsum); end
    tests++; if (beat_count !== 32'd8 || frame_count !== 16'd8) begin
      fails++; $display("FAIL bp_counts got=%0d/%0d exp=8/8", beat_count, frame_count); end
    tests++; if (seq_err_count !== 16'd0 || err_seq !== 1'b0) begin
      fails++; $display("FAIL bp_order got=%0d/%b exp=0/0", seq_err_count, err_seq); end
    pattern = 8'hFF;
  endtask

  task automatic test_frame_len();
    int w;
    pulse_clear();
    for (int i = 1; i <= 3; i++) send(8'(i), 1'b0, 1'b0, w);
    go_idle();
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL len_early got=%b exp=0", err_len); end
    send(8'd4, 1'b0, 1'b0, w);
    go_idle();
    tests++; if (err_len !== 1'b1 || frame_count !== 16'd0) begin
      fails++; $display("FAIL len_overrun got=%b/%0d exp=1/0", err_len, frame_count); end
    tests++; if (h_state !== 2'd2 || h_tready !== 1'b0 || h_beat_count !== 32'd4) begin
      fails++; $display("FAIL len_halt got=%0d/%b/%0d exp=2/0/4", h_state, h_tready, h_beat_count); end
    send(8'd5, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (frame_count !== 16'd1 || beat_count !== 32'd5 || err_seq !== 1'b0) begin
      fails++; $display("FAIL len_next_frame got=%0d/%0d/%b exp=1/5/0", frame_count, beat_count, err_seq); end
    tests++; if (h_beat_count !== 32'd4 || h_state !== 2'd2) begin
      fails++; $display("FAIL len_halt_hold got=%0d/%0d exp=4/2", h_beat_count, h_state); end
  endtask

  task automatic test_user_clear();
    int w;
    pulse_clear();
    send(8'd1, 1'b1, 1'b1, w);
    go_idle();
    tests++; if (err_user !== 1'b1 || frame_count !== 16'd1 || err_seq !== 1'b0) begin
      fails++; $display("FAIL user_flag got=%b/%0d/%b exp=1/1/0", err_user, frame_count, err_seq); end
    send(8'd7, 1'b1, 1'b1, w);
    go_idle();
    tests++; if (err_seq !== 1'b1 || seq_err_count !== 16'd1 || frame_count !== 16'd2) begin
      fails++; $display("FAIL user_and_seq got=%b/%0d/%0d exp=1/1/2", err_seq, seq_err_count, frame_count); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    tests++; if (frame_count !== 16'd0 || beat_count !== 32'd0 || seq_err_count !== 16'd0 ||
                 {err_seq, err_len, err_user, first_valid} !== 4'b0000 || state !== 2'd0) begin
      fails++; $display("FAIL clear_all got=%0d/%0d/%0d/%b/%0d exp=0/0/0/0000/0",
                        frame_count, beat_count, seq_err_count, {err_seq, err_len, err_user, first_valid}, state); end
    clear = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int w;
    for (int i = 1; i <= 3; i++) send(8'(i), 1'b0, 1'b0, w);
    go_idle();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (state !== 2'd0 || tready !== 1'b0 || beat_count !== 32'd0 || first_valid !== 1'b0 ||
                 first_data !== 8'd0 || frame_count !== 16'd0) begin
      fails++; $display("FAIL rst_mid got=%0d/%b/%0d/%b/%0d/%0d exp=0/0/0/0/0/0",
                        state, tready, beat_count, first_valid, first_data, frame_count); end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd1, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (err_seq !== 1'b0 || err_len !== 1'b0 || first_data !== 8'd1 ||
                 frame_count !== 16'd1 || beat_count !== 32'd1) begin
      fails++; $display("FAIL rst_restart got=%b/%b/%0d/%0d/%0d exp=0/0/1/1/1",
                        err_seq, err_len, first_data, frame_count, beat_count); end
  endtask

  task automatic test_enable_midframe();
    int w;
    send(8'd2, 1'b0, 1'b0, w);
    go_idle();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (state !== 2'd1 || tready !== 1'b1) begin
      fails++; $display("FAIL en_midframe got=%0d/%b exp=1/1", state, tready); end
    send(8'd3, 1'b1, 1'b0, w);
    go_idle();
    tests++; if (state !== 2'd0 || tready !== 1'b0 || frame_count !== 16'd2) begin
      fails++; $display("FAIL en_boundary got=%0d/%b/%0d exp=0/0/2", state, tready, frame_count); end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_seq_error();
    test_backpressure();
    test_frame_len();
    test_user_clear();
    test_reset_midframe();
    test_enable_midframe();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
